// File: rtl/KF8259_Common_Package.sv
// Shared types and helpers for the KF8259 interrupt-acknowledge logic.
// Holds the INTA# sequence state enum, the 8080 CALL opcode and level encoding.
package KF8259_Common_Package;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2,
        ACK3
    } inta_state_t;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    // Lowest set bit wins; no request encodes as IR7 so a spurious
    // acknowledge still produces a well-defined vector.
    function automatic logic [2:0] onehot_to_level(input logic [7:0] onehot);
        logic [2:0] lvl;
        lvl = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (onehot[i]) begin
                lvl = 3'(i);
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/kf8259_inta_edge_detect.sv
// Synchronizes the asynchronous INTA# pin and detects its edges.
// Ports: clock/reset, inta_n pin in; synced low level, fall/rise pulses out.
module kf8259_inta_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic inta_n,
    output logic inta_low,
    output logic inta_fall,
    output logic inta_rise
);

    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;
    logic prev_q;
    logic prev_d;

    always_comb begin
        sync1_d = inta_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Flops idle high so a pin held high through reset gives no edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign inta_low  = ~sync2_q;
    assign inta_fall = prev_q & ~sync2_q;
    assign inta_rise = ~prev_q & sync2_q;

endmodule

// File: rtl/kf8259_inta_sequencer.sv
// KF8259 INTA# cycle sequencer: raises INT, latches in-service, drives bytes.
// Ports: INTA# pin, mode/AEOI/vector config, request in; INT, ISR strobes, bus out.
module kf8259_inta_sequencer
    import KF8259_Common_Package::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt_acknowledge_n,
    input  logic        mode_8086,
    input  logic        auto_eoi,
    input  logic [7:0]  interrupt_request,
    input  logic [4:0]  vector_base,
    input  logic [15:0] address_8080,
    input  logic        interval_4,
    output logic        interrupt_out,
    output logic        latch_in_service,
    output logic [7:0]  interrupt_to_service,
    output logic [7:0]  clear_request,
    output logic [7:0]  end_of_interrupt,
    output logic [7:0]  data_out,
    output logic        data_out_enable
);

    logic inta_low;
    logic inta_fall;
    logic inta_rise;

    kf8259_inta_edge_detect u_edge (
        .clock     (clock),
        .reset     (reset),
        .inta_n    (interrupt_acknowledge_n),
        .inta_low  (inta_low),
        .inta_fall (inta_fall),
        .inta_rise (inta_rise)
    );

    inta_state_t state_q;
    inta_state_t state_d;
    logic        mode_q;
    logic        mode_d;
    logic [7:0]  level_q;
    logic [7:0]  level_d;
    logic        int_q;
    logic        int_d;
    logic        latch_q;
    logic        latch_d;
    logic [7:0]  its_q;
    logic [7:0]  its_d;
    logic [7:0]  clr_q;
    logic [7:0]  clr_d;
    logic [7:0]  eoi_q;
    logic [7:0]  eoi_d;
    logic [7:0]  data_q;
    logic [7:0]  data_d;
    logic        en_q;
    logic        en_d;

    logic        final_rise;
    logic [2:0]  code;
    logic [7:0]  bus_byte;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^address_8080[4:0];

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        level_d    = level_q;
        int_d      = 1'b0;
        latch_d    = 1'b0;
        clr_d      = 8'h00;
        eoi_d      = 8'h00;
        final_rise = 1'b0;

        unique case (state_q)
            IDLE: begin
                int_d = |interrupt_request;
                if (inta_fall) begin
                    state_d = ACK1;
                    mode_d  = mode_8086;
                    level_d = interrupt_request;
                    int_d   = 1'b0;
                    latch_d = |interrupt_request;
                    clr_d   = interrupt_request;
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    state_d = ACK2;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    if (mode_q) begin
                        state_d    = IDLE;
                        final_rise = 1'b1;
                    end else begin
                        state_d = ACK3;
                    end
                end
            end
            ACK3: begin
                if (inta_rise) begin
                    state_d    = IDLE;
                    final_rise = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A spurious sequence has level 0, so no in-service bit is cleared.
        if (final_rise && auto_eoi) begin
            eoi_d = level_q;
        end

        its_d = (state_d == IDLE) ? 8'h00 : level_d;
    end

    // Bus byte follows the upcoming state; byte fields are sampled live.
    always_comb begin
        code     = onehot_to_level(level_d);
        bus_byte = 8'h00;
        unique case (state_d)
            IDLE: bus_byte = 8'h00;
            ACK1: bus_byte = CALL_OPCODE;
            ACK2: begin
                if (mode_d) begin
                    bus_byte = {vector_base, code};
                end else if (interval_4) begin
                    bus_byte = {address_8080[7:5], code, 2'b00};
                end else begin
                    bus_byte = {address_8080[7:6], code, 3'b000};
                end
            end
            ACK3: bus_byte = address_8080[15:8];
            default: bus_byte = 8'h00;
        endcase

        // 8086 first pulse leaves the bus floating.
        en_d = (state_d != IDLE) && inta_low
            && !((state_d == ACK1) && mode_d);
        data_d = en_d ? bus_byte : 8'h00;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            level_q <= 8'h00;
            int_q   <= 1'b0;
            latch_q <= 1'b0;
            its_q   <= 8'h00;
            clr_q   <= 8'h00;
            eoi_q   <= 8'h00;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            level_q <= level_d;
            int_q   <= int_d;
            latch_q <= latch_d;
            its_q   <= its_d;
            clr_q   <= clr_d;
            eoi_q   <= eoi_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    assign interrupt_out        = int_q;
    assign latch_in_service     = latch_q;
    assign interrupt_to_service = its_q;
    assign clear_request        = clr_q;
    assign end_of_interrupt     = eoi_q;
    assign data_out             = data_q;
    assign data_out_enable      = en_q;

endmodule

// File: tb/tb_kf8259_inta_sequencer.sv
// Scoreboard bench for kf8259_inta_sequencer.
// Stimulus queues expected strobes/bytes; a negedge monitor pops and compares.
module tb_kf8259_inta_sequencer;

    logic        clock;
    logic        reset;
    logic        inta_n;
    logic        mode_8086;
    logic        auto_eoi;
    logic [7:0]  req;
    logic [4:0]  vector_base;
    logic [15:0] address_8080;
    logic        interval_4;
    logic        interrupt_out;
    logic        latch_in_service;
    logic [7:0]  interrupt_to_service;
    logic [7:0]  clear_request;
    logic [7:0]  end_of_interrupt;
    logic [7:0]  data_out;
    logic        data_out_enable;

    kf8259_inta_sequencer dut (
        .clock                   (clock),
        .reset                   (reset),
        .interrupt_acknowledge_n (inta_n),
        .mode_8086               (mode_8086),
        .auto_eoi                (auto_eoi),
        .interrupt_request       (req),
        .vector_base             (vector_base),
        .address_8080            (address_8080),
        .interval_4              (interval_4),
        .interrupt_out           (interrupt_out),
        .latch_in_service        (latch_in_service),
        .interrupt_to_service    (interrupt_to_service),
        .clear_request           (clear_request),
        .end_of_interrupt        (end_of_interrupt),
        .data_out                (data_out),
        .data_out_enable         (data_out_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam int K_LATCH = 0;
    localparam int K_BYTE  = 1;
    localparam int K_EOI   = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] act,
                             input string nm, output logic [7:0] exp_val);
        ev_t e;
        exp_val = 8'h00;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected actual=%h required=none", nm, act);
        end else begin
            e = exp_q.pop_front();
            exp_val = e.val;
            if (e.kind != kind || e.val !== act) begin
                errors++;
                $display("FAIL %s actual=%0d/%h required=%0d/%h",
                         nm, kind, act, e.kind, e.val);
            end
        end
    endtask

    logic       prev_en = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clock) begin
        logic [7:0] ev;
        if (!reset) begin
            if (latch_in_service) begin
                expect_ev(K_LATCH, interrupt_to_service, "latch", ev);
                check("clear_request", {8'h00, clear_request}, {8'h00, ev});
            end
            if (data_out_enable && !prev_en) begin
                expect_ev(K_BYTE, data_out, "bus_byte", ev);
            end
            if (data_out_enable && prev_en) begin
                check("bus_stable", {8'h00, data_out}, {8'h00, prev_data});
            end
            if (end_of_interrupt != 8'h00) begin
                expect_ev(K_EOI, end_of_interrupt, "eoi", ev);
            end
        end
        prev_en   = data_out_enable;
        prev_data = data_out;
    end

    task automatic pulse();
        @(posedge clock);
        #1 inta_n = 1'b0;
        repeat (5) @(posedge clock);
        #1 inta_n = 1'b1;
        repeat (5) @(posedge clock);
    endtask

    task automatic check_int(input string nm, input logic exp);
        @(negedge clock);
        check(nm, {15'h0, interrupt_out}, {15'h0, exp});
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_int"}, {15'h0, interrupt_out}, 16'h0);
        check({nm, "_latch"}, {15'h0, latch_in_service}, 16'h0);
        check({nm, "_its"}, {8'h0, interrupt_to_service}, 16'h0);
        check({nm, "_clr"}, {8'h0, clear_request}, 16'h0);
        check({nm, "_eoi"}, {8'h0, end_of_interrupt}, 16'h0);
        check({nm, "_data"}, {8'h0, data_out}, 16'h0);
        check({nm, "_en"}, {15'h0, data_out_enable}, 16'h0);
    endtask

    initial begin
        bit seen;
        reset        = 1'b1;
        inta_n       = 1'b1;
        mode_8086    = 1'b1;
        auto_eoi     = 1'b0;
        req          = 8'h00;
        vector_base  = 5'b01000;
        address_8080 = 16'h0000;
        interval_4   = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock);
        #1 reset = 1'b0;

        // 8086 basic, no AEOI
        req = 8'h04;
        repeat (3) @(posedge clock);
        check_int("int_rise_8086", 1'b1);
        push(K_LATCH, 8'h04);
        pulse();
        check_int("int_low_ack", 1'b0);
        req = 8'h00;
        push(K_BYTE, 8'h42);
        pulse();
        repeat (3) @(posedge clock);
        check_int("int_stay_low", 1'b0);

        // 8086 with AEOI on IR7
        auto_eoi = 1'b1;
        req = 8'h80;
        repeat (3) @(posedge clock);
        push(K_LATCH, 8'h80);
        pulse();
        req = 8'h00;
        push(K_BYTE, 8'h47);
        push(K_EOI, 8'h80);
        pulse();

        // 8080, interval 4, AEOI
        mode_8086    = 1'b0;
        address_8080 = 16'h12E0;
        interval_4   = 1'b1;
        req = 8'h08;
        repeat (3) @(posedge clock);
        push(K_LATCH, 8'h08);
        push(K_BYTE, 8'hCD);
        pulse();
        check_int("int_low_8080_ack2", 1'b0);
        push(K_BYTE, 8'hEC);
        pulse();
        check_int("int_low_8080_ack3", 1'b0);
        push(K_BYTE, 8'h12);
        push(K_EOI, 8'h08);
        pulse();
        repeat (3) @(posedge clock);
        check_int("int_reassert", 1'b1);
        req = 8'h00;
        repeat (3) @(posedge clock);

        // 8080, interval 8, no AEOI
        auto_eoi   = 1'b0;
        interval_4 = 1'b0;
        req = 8'h02;
        repeat (3) @(posedge clock);
        push(K_LATCH, 8'h02);
        push(K_BYTE, 8'hCD);
        pulse();
        req = 8'h00;
        push(K_BYTE, 8'hC8);
        pulse();
        push(K_BYTE, 8'h12);
        pulse();

        // spurious acknowledge in 8086 mode
        mode_8086   = 1'b1;
        auto_eoi    = 1'b1;
        vector_base = 5'b11111;
        pulse();
        push(K_BYTE, 8'hFF);
        pulse();
        check_int("int_spurious", 1'b0);

        // reset during ACK2
        vector_base = 5'b00001;
        req = 8'h01;
        repeat (3) @(posedge clock);
        push(K_LATCH, 8'h01);
        pulse();
        req = 8'h00;
        push(K_BYTE, 8'h08);
        @(posedge clock);
        #1 inta_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (data_out_enable) begin
                seen = 1'b1;
                break;
            end
        end
        check("ack2_enable_seen", {15'h0, seen}, 16'h1);
        #1 reset = 1'b1;
        inta_n = 1'b1;
        @(negedge clock);
        check_all_zero("midreset");
        @(posedge clock);
        #1 reset = 1'b0;
        req = 8'h02;
        repeat (3) @(posedge clock);
        check_int("int_after_reset", 1'b1);
        push(K_LATCH, 8'h02);
        pulse();
        req = 8'h00;
        push(K_BYTE, 8'h09);
        push(K_EOI, 8'h02);
        pulse();

        // mode toggled mid-sequence: 8086 capture must finish in two pulses
        vector_base = 5'b01000;
        req = 8'h10;
        repeat (3) @(posedge clock);
        push(K_LATCH, 8'h10);
        pulse();
        mode_8086 = 1'b0;
        push(K_BYTE, 8'h44);
        push(K_EOI, 8'h10);
        pulse();
        repeat (3) @(posedge clock);
        check_int("int_after_toggle", 1'b1);
        req = 8'h00;
        mode_8086 = 1'b1;

        repeat (5) @(posedge clock);
        @(negedge clock);
        check("queue_empty", 16'(exp_q.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
